ext_mem_loader: RTL and testbench
=================================

Name: ext_mem_loader

Overview:
- Byte-stream program/data loader that acts as the initiator on the CPU top's external memory-write port (Ext_MemWrite / Ext_DataAdr / Ext_WriteData).
- Holds the CPU in reset, assembles incoming bytes into little-endian 32-bit words, and writes them to consecutive data-memory addresses.
- Releases the CPU once the declared word count is written.
- Sits between a byte source (UART receiver, testbench, debug FIFO) and the CPU top.

Parameters:
- BASE_ADDR, 32'h0000_0000, address of the first word written.
- ADDR_STEP, 4, byte increment between consecutive word writes.
- MAX_WORDS, 64, largest accepted word count; a larger count is an error.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- load_start  input  1  single-cycle pulse; starts a load from IDLE or DONE, ignored otherwise.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts the byte this cycle; transfer = in_valid & in_ready.
- cpu_reset  output  1  active-high reset to the CPU top; 1 while loading.
- Ext_MemWrite  output  1  one-cycle word write strobe.
- Ext_DataAdr  output  32  write address.
- Ext_WriteData  output  32  write data.
- busy  output  1  high in HDR/DATA/WRITE(/CHK).
- done  output  1  high in DONE.
- error  output  1  high in ERR.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - cpu_reset=1; Ext_MemWrite=0; Ext_DataAdr=BASE_ADDR; Ext_WriteData=0; in_ready=0; busy=done=error=0.
  - Byte counter, word counter and count register are cleared.
  - Asserting reset mid-load abandons the load; already-written words are not undone.
- All outputs are registered.
- Frame format:
  - 4 header bytes carry the word count N, little-endian (first byte = bits 7:0).
  - Then 4N data bytes, each word little-endian.
- IDLE: in_ready=0, cpu_reset=1. load_start -> HDR, clearing the counters.
- HDR:
  - in_ready=1; accepts 4 bytes.
  - After the 4th byte: N=0 -> DONE; N>MAX_WORDS -> ERR; else -> DATA.
- DATA:
  - in_ready=1; bytes shift into a word register at lanes [7:0], [15:8], [23:16], [31:24] in arrival order.
  - The 4th byte accepted in cycle t -> WRITE in cycle t+1.
- WRITE (exactly 1 cycle):
  - Ext_MemWrite=1, Ext_DataAdr=BASE_ADDR+k*ADDR_STEP (k = word index from 0), Ext_WriteData=assembled word, in_ready=0.
  - Then k increments. If k+1==N -> DONE (or CHK with the feature); else -> DATA.
- Back-pressure: in_ready is only ever low in IDLE, WRITE, DONE and ERR. in_valid=0 stalls with no state change. Gaps between bytes are unbounded.
- DONE:
  - cpu_reset=0 from the first DONE cycle; done=1; in_ready=0.
  - load_start -> HDR, re-asserting cpu_reset=1 in the next cycle.
- ERR: cpu_reset stays 1, error=1, in_ready=0. Exit only via load_start (-> HDR, error cleared).
- Ext_MemWrite is asserted only while cpu_reset=1. The top muxes external writes only during CPU reset, so this is mandatory.
- Address arithmetic is 32-bit modulo 2^32; wrap is permitted and not flagged.
- load_start in HDR/DATA/WRITE is ignored.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, state CHK (in_ready=1) accepts one byte.
  - The byte is compared to the XOR of all 4N data bytes (header excluded).
  - Match -> DONE; mismatch -> ERR.
  - For N=0 the expected checksum is 8'h00 and CHK follows HDR.
- Not defined: no CHK state; the last WRITE goes directly to DONE, and N=0 goes HDR->DONE.

Test Plan:
- Reset: hold reset=0 mid-DATA -> cpu_reset=1, Ext_MemWrite=0, Ext_DataAdr=BASE_ADDR, busy=0 immediately (asynchronous). Release -> IDLE.
- Basic load: load_start; bytes 02 00 00 00, EF BE AD DE, 78 56 34 12 ->
  - write 0xDEADBEEF @0x0, then 0x12345678 @0x4;
  - one-cycle strobes; in_ready=0 on each strobe cycle;
  - done=1, cpu_reset=0 in the cycle after the second strobe.
- Stall: same frame with in_valid low 3 cycles between every byte -> identical writes, no extra strobes.
- Zero/oversize count: N=0 -> DONE, no write strobe. N=65 with MAX_WORDS=64 -> error=1, cpu_reset=1, no write.
- Reload: after DONE, load_start; N=1, bytes 01 02 03 04 -> cpu_reset=1 again, write 0x04030201 @0x0, DONE.
- Checksum (LOADER_CHECKSUM_EN): N=1, data AA 55 0F F0, checksum 00 -> DONE. Checksum 01 -> ERR, cpu_reset stays 1.

Source files
------------

// File: rtl/ext_mem_loader.sv
// Byte-stream loader: holds CPU in reset, packs LE bytes into words, writes them to consecutive addresses.
// Latency: write strobe one cycle after the 4th byte of a word; all outputs registered.
// Backpressure: in_ready low only in IDLE/WRITE/DONE/ERR; optional LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module ext_mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        cpu_reset,
    output logic        Ext_MemWrite,
    output logic [31:0] Ext_DataAdr,
    output logic [31:0] Ext_WriteData,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int WCW = $clog2(MAX_WORDS + 1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;
`endif

    state_t           state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [WCW-1:0]   word_cnt_q, word_cnt_d;
    logic [WCW-1:0]   count_q, count_d;
    logic [31:0]      word_q, word_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             in_ready_q, in_ready_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             mem_write_q, mem_write_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic        xfer;
    logic [31:0] shifted;

    assign xfer    = in_valid & in_ready_q;
    // New byte enters at the top so the first byte ends up in bits 7:0.
    assign shifted = {in_data, word_q[31:8]};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        count_d    = count_q;
        word_d     = word_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_start) begin
                    state_d    = S_HDR;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    count_d    = '0;
                    word_d     = '0;
                    adr_d      = BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            S_HDR: begin
                if (xfer) begin
                    word_d     = shifted;
                    byte_cnt_d = 2'(byte_cnt_q + 2'd1);
                    if (byte_cnt_q == 2'd3) begin
                        if (shifted == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d = S_DONE;
`endif
                        end else if (shifted > 32'(MAX_WORDS)) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                            count_d = shifted[WCW-1:0];
                        end
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d     = shifted;
                    byte_cnt_d = 2'(byte_cnt_q + 2'd1);
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ in_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        wdata_d = shifted;
                    end
                end
            end
            S_WRITE: begin
                word_cnt_d = WCW'(word_cnt_q + 1'b1);
                adr_d      = adr_q + 32'(ADDR_STEP);
                if (WCW'(word_cnt_q + 1'b1) == count_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        in_ready_d  = (state_d == S_HDR) || (state_d == S_DATA);
        busy_d      = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_WRITE);
`ifdef LOADER_CHECKSUM_EN
        in_ready_d  = in_ready_d || (state_d == S_CHK);
        busy_d      = busy_d || (state_d == S_CHK);
`endif
        cpu_reset_d = (state_d != S_DONE);
        mem_write_d = (state_d == S_WRITE);
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            count_q     <= '0;
            word_q      <= '0;
            adr_q       <= BASE_ADDR;
            wdata_q     <= '0;
            in_ready_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            count_q     <= count_d;
            word_q      <= word_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            in_ready_q  <= in_ready_d;
            cpu_reset_q <= cpu_reset_d;
            mem_write_q <= mem_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign in_ready      = in_ready_q;
    assign cpu_reset     = cpu_reset_q;
    assign Ext_MemWrite  = mem_write_q;
    assign Ext_DataAdr   = adr_q;
    assign Ext_WriteData = wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_ext_mem_loader.sv
// Directed bench for ext_mem_loader: frames driven byte by byte, outputs sampled on the falling edge.
module tb_ext_mem_loader;

    logic        clk;
    logic        reset;
    logic        load_start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        cpu_reset;
    logic        Ext_MemWrite;
    logic [31:0] Ext_DataAdr;
    logic [31:0] Ext_WriteData;
    logic        busy;
    logic        done;
    logic        error;

    int n_chk  = 0;
    int n_pass = 0;
    int wr_total = 0;
    int wr_bad   = 0;
    int wr_base  = 0;
    logic prev_mw = 1'b0;

    ext_mem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .cpu_reset    (cpu_reset),
        .Ext_MemWrite (Ext_MemWrite),
        .Ext_DataAdr  (Ext_DataAdr),
        .Ext_WriteData(Ext_WriteData),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts strobes and flags any that last >1 cycle, overlap in_ready, or occur with the CPU released.
    always @(negedge clk) begin
        if (Ext_MemWrite) begin
            wr_total = wr_total + 1;
            if (prev_mw || in_ready || !cpu_reset) wr_bad = wr_bad + 1;
        end
        prev_mw = Ext_MemWrite;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Returns on the falling edge right after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("rdy_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = w >> (8 * i);
            send_byte(t[7:0], gap);
        end
    endtask

    task automatic check_write(input string tag, input logic [31:0] adr, input logic [31:0] dat);
        chk({tag, "_mw"},  {31'd0, Ext_MemWrite}, 32'd1);
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_adr"}, Ext_DataAdr, adr);
        chk({tag, "_dat"}, Ext_WriteData, dat);
    endtask

    task automatic end_frame(input string tag, input logic [7:0] cs, input int nwr);
`ifdef LOADER_CHECKSUM_EN
        send_byte(cs, 0);
`else
        @(negedge clk);
`endif
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_cpurst"}, {31'd0, cpu_reset}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        #1;
        chk({tag, "_nwr"}, wr_total - wr_base, nwr);
    endtask

    initial begin
        reset = 1'b0;
        load_start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("rst_mw", {31'd0, Ext_MemWrite}, 32'd0);
        chk("rst_adr", Ext_DataAdr, 32'h0);
        chk("rst_dat", Ext_WriteData, 32'h0);
        chk("rst_flags", {28'd0, in_ready, busy, done, error}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_rdy", {31'd0, in_ready}, 32'd0);

        // Basic two-word load
        wr_base = wr_total;
        pulse_start();
        chk("hdr_busy", {30'd0, busy, in_ready}, 32'h3);
        send_word(32'd2, 0);
        send_word(32'hDEADBEEF, 0);
        check_write("b0", 32'h0, 32'hDEADBEEF);
        send_word(32'h12345678, 0);
        check_write("b1", 32'h4, 32'h12345678);
        end_frame("basic", 8'h2A, 2);

        // Same frame with 3-cycle gaps; a stray load_start mid-DATA must be ignored
        wr_base = wr_total;
        pulse_start();
        send_word(32'd2, 3);
        send_byte(8'hEF, 3);
        pulse_start();
        send_byte(8'hBE, 3);
        send_byte(8'hAD, 3);
        send_byte(8'hDE, 3);
        check_write("s0", 32'h0, 32'hDEADBEEF);
        send_word(32'h12345678, 3);
        check_write("s1", 32'h4, 32'h12345678);
        end_frame("stall", 8'h2A, 2);

        // Oversize count
        wr_base = wr_total;
        pulse_start();
        send_word(32'd65, 0);
        chk("ovr_err", {31'd0, error}, 32'd1);
        chk("ovr_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("ovr_rdy", {30'd0, in_ready, busy}, 32'd0);
        #1;
        chk("ovr_nwr", wr_total - wr_base, 0);

        // Zero count, leaving ERR
        wr_base = wr_total;
        pulse_start();
        chk("zero_errclr", {31'd0, error}, 32'd0);
        send_word(32'd0, 0);
        end_frame("zero", 8'h00, 0);

        // Reload from DONE
        wr_base = wr_total;
        pulse_start();
        chk("rel_cpurst", {31'd0, cpu_reset}, 32'd1);
        send_word(32'd1, 0);
        send_word(32'h04030201, 0);
        check_write("r0", 32'h0, 32'h04030201);
        end_frame("reload", 8'h04, 1);

`ifdef LOADER_CHECKSUM_EN
        wr_base = wr_total;
        pulse_start();
        send_word(32'd1, 0);
        send_word(32'hF00F55AA, 0);
        check_write("c0", 32'h0, 32'hF00F55AA);
        end_frame("csum_ok", 8'h00, 1);
        pulse_start();
        send_word(32'd1, 0);
        send_word(32'hF00F55AA, 0);
        send_byte(8'h01, 0);
        chk("csum_bad_err", {31'd0, error}, 32'd1);
        chk("csum_bad_cpurst", {31'd0, cpu_reset}, 32'd1);
`endif

        // Asynchronous reset in the middle of DATA
        wr_base = wr_total;
        pulse_start();
        send_word(32'd2, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("arst_mw", {31'd0, Ext_MemWrite}, 32'd0);
        chk("arst_adr", Ext_DataAdr, 32'h0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_idle", {28'd0, in_ready, busy, done, error}, 32'h0);
        chk("arst_nwr", wr_total - wr_base, 0);
        chk("strobe_bad", wr_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
